// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory subsystem.
// FSM state codes and transaction owner encoding.
package mips_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between fetch and data ports.
// One transaction in flight; data wins unless fetch has been starved.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_DBURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  function automatic int cw(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int LW = cw(MEM_LAT + 1);
  localparam int BW = cw(MAX_DBURST + 1);
  localparam logic [LW-1:0] LAT_LD = LW'(MEM_LAT - 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_DBURST);

  logic [1:0]    state;
  logic          owner;
  logic          d_store;
  logic [LW-1:0] lat_cnt;
  logic [BW-1:0] burst_cnt;
  logic          pick_d;
  logic          pick_if;

  // Fetch only overtakes a pending data request once starved.
  assign pick_d  = d_req & (~if_req | (burst_cnt != BMAX));
  assign pick_if = if_req & ~pick_d;

  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      d_store   <= 1'b0;
      lat_cnt   <= '0;
      burst_cnt <= '0;
      if_rdata  <= '0;
      if_ack    <= 1'b0;
      d_rdata   <= '0;
      d_ack     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d) begin
            owner     <= OWN_D;
            d_store   <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_we    <= d_we;
            mem_en    <= 1'b1;
            lat_cnt   <= LAT_LD;
            state     <= ACCESS;
            if (!if_req)
              burst_cnt <= '0;
            else if (burst_cnt != BMAX)
              burst_cnt <= burst_cnt + 1'b1;
          end else if (pick_if) begin
            owner     <= OWN_IF;
            d_store   <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_en    <= 1'b1;
            lat_cnt   <= LAT_LD;
            burst_cnt <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (lat_cnt == '0) begin
            mem_en <= 1'b0;
            state  <= RESP;
            if (owner == OWN_IF) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              if (!d_store) d_rdata <= mem_rdata;
              d_ack <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
